// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//   FSM controller for the multi-cycle MIPS-subset CPU. Each instruction is
//   sequenced through IF / ID / EXE / MEM / WB states, and the unit drives
//   every datapath enable and mux select for that state.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous reset, active low (CPU runs while RST=1)
//   opCode     in   IR[31:26]
//   zero       in   ALU result == 0
//   state      out  current FSM state
//   PCWre, IRWre, InsMemRW, RegWre, mRD, mWR       out  enables
//   ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc out  1-bit selects
//   RegDst[1:0], PCSrc[1:0], ALUOp[2:0]            out  multi-bit selects
// ---------------------------------------------------------------------------
module multicycle_control_unit (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] opCode,
   input  logic       zero,
   output logic [2:0] state,
   output logic       PCWre,
   output logic       IRWre,
   output logic       InsMemRW,
   output logic       RegWre,
   output logic       mRD,
   output logic       mWR,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       ExtSel,
   output logic       DBDataSrc,
   output logic       WrRegDSrc,
   output logic [1:0] RegDst,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp
);

   localparam logic [2:0] S_IF      = 3'b000;
   localparam logic [2:0] S_ID      = 3'b001;
   localparam logic [2:0] S_EXE_MEM = 3'b010;
   localparam logic [2:0] S_MEM     = 3'b011;
   localparam logic [2:0] S_WB_LD   = 3'b100;
   localparam logic [2:0] S_EXE_BR  = 3'b101;
   localparam logic [2:0] S_EXE_AL  = 3'b110;
   localparam logic [2:0] S_WB_AL   = 3'b111;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLTI  = 6'b100110;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   logic [2:0] state_q, state_d;
   logic       is_alu, is_imm, is_rtype;
   logic [2:0] alu_op;

   // opcode decode shared by next-state and output logic
   always_comb begin
      is_rtype = (opCode == OP_ADD) || (opCode == OP_SUB) || (opCode == OP_AND);
      is_imm   = (opCode == OP_ADDIU) || (opCode == OP_ANDI) ||
                 (opCode == OP_ORI)   || (opCode == OP_SLTI);
      is_alu   = is_rtype || is_imm;
      unique case (opCode)
         OP_SUB:            alu_op = 3'b001;
         OP_SLTI:           alu_op = 3'b010;
         OP_ORI:            alu_op = 3'b100;
         OP_AND, OP_ANDI:   alu_op = 3'b101;
         default:           alu_op = 3'b000;
      endcase
   end

   // state register
   always_ff @(posedge CLK) begin
      if (!RST) state_q <= S_IF;
      else      state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            if (opCode == OP_HALT)                           state_d = S_ID;
            else if (opCode == OP_BEQ || opCode == OP_BNE)   state_d = S_EXE_BR;
            else if (opCode == OP_LW  || opCode == OP_SW)    state_d = S_EXE_MEM;
            else if (is_alu)                                 state_d = S_EXE_AL;
            else                                             state_d = S_IF; // jumps, nop
         end
         S_EXE_AL:  state_d = S_WB_AL;
         S_WB_AL:   state_d = S_IF;
         S_EXE_BR:  state_d = S_IF;
         S_EXE_MEM: state_d = S_MEM;
         S_MEM:     state_d = (opCode == OP_LW) ? S_WB_LD : S_IF;
         S_WB_LD:   state_d = S_IF;
         default:   state_d = S_IF;
      endcase
   end

   // output logic
   always_comb begin
      PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; RegWre = 1'b0;
      mRD = 1'b0; mWR = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0;
      ExtSel = 1'b0; DBDataSrc = 1'b0; WrRegDSrc = 1'b0;
      RegDst = 2'b00; PCSrc = 2'b00; ALUOp = 3'b000;
      case (state_q)
         S_IF: begin
            IRWre    = 1'b1;
            InsMemRW = 1'b1;
         end
         S_ID: begin
            case (opCode)
               OP_J:  begin PCSrc = 2'b11; PCWre = 1'b1; end
               OP_JR: begin PCSrc = 2'b10; PCWre = 1'b1; end
               OP_JAL: begin
                  PCSrc  = 2'b11; PCWre = 1'b1;
                  RegWre = 1'b1;  RegDst = 2'b00; WrRegDSrc = 1'b0;
               end
               OP_HALT, OP_BEQ, OP_BNE, OP_LW, OP_SW: ;
               default: begin
                  // unknown opcodes retire here as a nop
                  if (!is_alu) PCWre = 1'b1;
               end
            endcase
         end
         S_EXE_AL: begin
            ALUSrcB = is_imm;
            ExtSel  = (opCode == OP_ADDIU) || (opCode == OP_SLTI);
            ALUOp   = alu_op;
         end
         S_WB_AL: begin
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = is_rtype ? 2'b10 : 2'b01;
            ALUOp     = alu_op;
            PCWre     = 1'b1;
         end
         S_EXE_BR: begin
            ALUOp  = 3'b001;
            ExtSel = 1'b1;
            PCWre  = 1'b1;
            if (((opCode == OP_BEQ) && zero) || ((opCode == OP_BNE) && !zero))
               PCSrc = 2'b01;
         end
         S_EXE_MEM: begin
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
         end
         S_MEM: begin
            if (opCode == OP_SW) begin
               mWR   = 1'b1;
               PCWre = 1'b1;
            end else if (opCode == OP_LW) begin
               mRD = 1'b1;
            end
         end
         S_WB_LD: begin
            mRD       = 1'b1;
            DBDataSrc = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = 2'b01;
            RegWre    = 1'b1;
            PCWre     = 1'b1;
         end
         default: ;
      endcase
      // an edge taken under reset must not commit any architectural write
      if (!RST) begin
         PCWre = 1'b0; IRWre = 1'b0; RegWre = 1'b0; mWR = 1'b0; mRD = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

   logic       CLK, RST, zero;
   logic [5:0] opCode;
   logic [2:0] state;
   logic       PCWre, IRWre, InsMemRW, RegWre, mRD, mWR;
   logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] ALUOp;

   int n_chk  = 0;
   int n_fail = 0;

   multicycle_control_unit dut (
      .CLK(CLK), .RST(RST), .opCode(opCode), .zero(zero), .state(state),
      .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
      .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
      .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp)
   );

   // {state, PCWre IRWre InsMemRW RegWre mRD mWR ALUSrcA ALUSrcB ExtSel
   //  DBDataSrc WrRegDSrc, RegDst, PCSrc, ALUOp}
   logic [20:0] obs;
   assign obs = {state, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA,
                 ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp};

   localparam logic [20:0] V_IF     = {3'b000, 18'b01100000000_00_00_000};
   localparam logic [20:0] V_IF_RST = {3'b000, 18'b00100000000_00_00_000};
   localparam logic [20:0] V_ID0    = {3'b001, 18'b00000000000_00_00_000};
   localparam logic [20:0] V_EXMEM  = {3'b010, 18'b00000001100_00_00_000};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic test_reset();
      RST = 1'b0; zero = 1'b0; opCode = 6'b000011; // nop
      for (int i = 0; i < 5; i++) begin
         step();
         n_chk++;
         if ({state, PCWre, IRWre, RegWre, mWR, mRD} !== 8'b000_00000) begin
            n_fail++;
            $display("FAIL reset cyc=%0d got state=%b en=%b%b%b%b%b expected 000/00000",
                     i, state, PCWre, IRWre, RegWre, mWR, mRD);
         end
      end
      RST = 1'b1; #1;
      n_chk++;
      if (obs !== V_IF) begin
         n_fail++; $display("FAIL reset_release got=%b expected=%b", obs, V_IF);
      end
      step();
      n_chk++;
      if (obs !== {3'b001, 18'b10000000000_00_00_000}) begin
         n_fail++; $display("FAIL reset_first_id got=%b expected=%b", obs,
                            {3'b001, 18'b10000000000_00_00_000});
      end
      step();
      n_chk++;
      if (obs !== V_IF) begin
         n_fail++; $display("FAIL nop_retire got=%b expected=%b", obs, V_IF);
      end
   endtask

   // four-state ALU instruction: IF, ID, EXE_AL, WB_AL, back to IF
   task automatic test_alu(input logic [5:0] op, input logic [20:0] exe,
                           input logic [20:0] wb);
      logic [20:0] exp [5];
      exp = '{V_IF, V_ID0, exe, wb, V_IF};
      opCode = op; #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         n_chk++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL alu op=%b cyc=%0d got=%b expected=%b", op, i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_lw_sw();
      logic [20:0] exp_lw [6];
      logic [20:0] exp_sw [5];
      exp_lw = '{V_IF, V_ID0, V_EXMEM,
                 {3'b011, 18'b00001000000_00_00_000},
                 {3'b100, 18'b10011000011_01_00_000}, V_IF};
      exp_sw = '{V_IF, V_ID0, V_EXMEM,
                 {3'b011, 18'b10000100000_00_00_000}, V_IF};
      opCode = 6'b110001; #1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         n_chk++;
         if (obs !== exp_lw[i]) begin
            n_fail++; $display("FAIL lw cyc=%0d got=%b expected=%b", i, obs, exp_lw[i]);
         end
      end
      opCode = 6'b110000; #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         n_chk++;
         if (obs !== exp_sw[i]) begin
            n_fail++; $display("FAIL sw cyc=%0d got=%b expected=%b", i, obs, exp_sw[i]);
         end
      end
   endtask

   task automatic test_branch(input logic [5:0] op, input logic z, input logic [1:0] pcsrc);
      logic [20:0] exp [4];
      exp = '{V_IF, V_ID0, {3'b101, 9'b100000001, 4'b0000, pcsrc, 3'b001}, V_IF};
      opCode = op; zero = z; #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         n_chk++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL branch op=%b zero=%b cyc=%0d got=%b expected=%b",
                     op, z, i, obs, exp[i]);
         end
      end
      zero = 1'b0;
   endtask

   // two-state instructions that retire in ID
   task automatic test_jump(input logic [5:0] op, input logic [20:0] id_exp);
      logic [20:0] exp [3];
      exp = '{V_IF, id_exp, V_IF};
      opCode = op; #1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         n_chk++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL jump op=%b cyc=%0d got=%b expected=%b", op, i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid_sw();
      opCode = 6'b110000; #1;
      step(); step(); step();
      n_chk++;
      if (obs !== {3'b011, 18'b10000100000_00_00_000}) begin
         n_fail++; $display("FAIL rst_mid_pre got=%b expected=%b", obs,
                            {3'b011, 18'b10000100000_00_00_000});
      end
      RST = 1'b0; #1;
      n_chk++;
      if (obs !== {3'b011, 18'b0}) begin
         n_fail++; $display("FAIL rst_mid_mem got=%b expected=%b", obs, {3'b011, 18'b0});
      end
      step();
      n_chk++;
      if (obs !== V_IF_RST) begin
         n_fail++; $display("FAIL rst_mid_if got=%b expected=%b", obs, V_IF_RST);
      end
      RST = 1'b1; #1;
      n_chk++;
      if (obs !== V_IF) begin
         n_fail++; $display("FAIL rst_mid_release got=%b expected=%b", obs, V_IF);
      end
   endtask

   task automatic test_halt();
      opCode = 6'b111111; #1;
      for (int i = 0; i < 21; i++) begin
         step();
         n_chk++;
         if (obs !== V_ID0) begin
            n_fail++; $display("FAIL halt cyc=%0d got=%b expected=%b", i, obs, V_ID0);
         end
      end
      RST = 1'b0;
      step();
      RST = 1'b1; #1;
      n_chk++;
      if (obs !== V_IF) begin
         n_fail++; $display("FAIL halt_exit got=%b expected=%b", obs, V_IF);
      end
   endtask

   initial begin
      test_reset();
      // add: R-type, RegDst=10, ALUOp=000
      test_alu(6'b000000, {3'b110, 18'b00000000000_00_00_000},
                          {3'b111, 18'b10010000001_10_00_000});
      // sub: ALUOp=001
      test_alu(6'b000001, {3'b110, 18'b00000000000_00_00_001},
                          {3'b111, 18'b10010000001_10_00_001});
      // slti: imm, sign-extend, ALUOp=010, RegDst=01
      test_alu(6'b100110, {3'b110, 18'b00000001100_00_00_010},
                          {3'b111, 18'b10010000001_01_00_010});
      // ori: imm, zero-extend, ALUOp=100
      test_alu(6'b010010, {3'b110, 18'b00000001000_00_00_100},
                          {3'b111, 18'b10010000001_01_00_100});
      // andi: imm, zero-extend, ALUOp=101
      test_alu(6'b010001, {3'b110, 18'b00000001000_00_00_101},
                          {3'b111, 18'b10010000001_01_00_101});
      test_lw_sw();
      test_branch(6'b110100, 1'b1, 2'b01);
      test_branch(6'b110100, 1'b0, 2'b00);
      test_branch(6'b110101, 1'b1, 2'b00);
      test_branch(6'b110101, 1'b0, 2'b01);
      test_jump(6'b111010, {3'b001, 18'b10010000000_00_11_000}); // jal
      test_jump(6'b111000, {3'b001, 18'b10000000000_00_11_000}); // j
      test_jump(6'b111001, {3'b001, 18'b10000000000_00_10_000}); // jr
      test_jump(6'b101010, {3'b001, 18'b10000000000_00_00_000}); // nop
      test_reset_mid_sw();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Finite-state controller for the multi-cycle MIPS-subset CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB and drives every datapath enable and mux select.
- Inputs are the IR opcode and the ALU flags. It sits inside CPU beside the register file, ALU, IR and memories.
- Exposes its current state for the simulation bench.

Parameters:
- None. Opcode and state encodings are fixed below.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-low; CPU runs while RST=1
- opCode  in  6  IR[31:26], stable from ID onward
- zero  in  1  ALU result==0
- state  out  3  current state: IF=000 ID=001 EXE_AL=110 WB_AL=111 EXE_BR=101 EXE_MEM=010 MEM=011 WB_LD=100
- PCWre  out  1  PC write enable
- IRWre  out  1  IR load enable
- InsMemRW  out  1  instruction memory read (1=read)
- RegWre  out  1  register file write enable
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- ALUSrcA  out  1  0=rs, 1=sa (unused, always 0 in this subset)
- ALUSrcB  out  1  0=rt, 1=extended imm
- ExtSel  out  1  0=zero-extend, 1=sign-extend
- DBDataSrc  out  1  0=ALU out, 1=data memory out
- WrRegDSrc  out  1  0=PC+4 (jal), 1=DB bus
- RegDst  out  2  00=$31, 01=rt, 10=rd
- PCSrc  out  2  00=PC+4, 01=PC+4+(sext imm<<2), 10=rs, 11={PC+4[31:28],addr,00}
- ALUOp  out  3  000 add, 001 sub, 010 slt signed, 100 or, 101 and

Behaviour:
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, slti 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode is a nop.
- Reset: if RST=0 at a rising CLK, state<=IF. While RST=0, PCWre, IRWre, RegWre, mWR and mRD are combinationally forced to 0.
- Outputs are combinational from the registered state and opCode. Unlisted outputs are 0 in every state.
- IF: IRWre=1, InsMemRW=1. Next state ID.
- ID:
  - j: PCSrc=11, PCWre=1, next IF.
  - jr: PCSrc=10, PCWre=1, next IF.
  - jal: PCSrc=11, PCWre=1, RegWre=1, RegDst=00, WrRegDSrc=0, next IF.
  - halt: all enables 0; state stays ID until reset.
  - nop: PCWre=1, PCSrc=00, next IF.
  - beq/bne: next EXE_BR.
  - lw/sw: next EXE_MEM.
  - All other opcodes: next EXE_AL.
- EXE_AL:
  - ALUSrcB=1 for addiu/andi/ori/slti.
  - ExtSel=1 for addiu/slti, 0 for andi/ori.
  - ALUOp per opcode: add/addiu 000, sub 001, slti 010, ori 100, and/andi 101.
  - Next WB_AL.
- WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=10 (R-type) or 01 (immediate forms), ALUOp held, PCWre=1, PCSrc=00. Next IF.
- EXE_BR: ALUOp=001, ALUSrcB=0, ExtSel=1, PCWre=1. PCSrc=01 if (beq & zero) or (bne & ~zero), else 00. Next IF.
- EXE_MEM: ALUOp=000, ALUSrcB=1, ExtSel=1. Next MEM.
- MEM:
  - sw: mWR=1, PCWre=1, PCSrc=00, next IF.
  - lw: mRD=1, next WB_LD.
- WB_LD: mRD=1, DBDataSrc=1, WrRegDSrc=1, RegDst=01, RegWre=1, PCWre=1, PCSrc=00. Next IF.
- Cycles per instruction: j/jr/jal/nop 2, beq/bne 3, ALU and sw 4, lw 5.
- PCWre is asserted exactly once per instruction, in its final state.
- Reset mid-instruction aborts the instruction. No write enable is asserted at that edge. State returns to IF.
- The 3-bit state never takes an illegal value. As a safety rule, any unencoded value goes to IF.

Test Plan:
- Reset: RST=0 for 5 cycles, then 1. State reads 000 at every edge during reset with all enables 0; IF→ID on the first edge after release.
- add (000000): state sequence 000,001,110,111,000. In WB_AL, RegWre=1, RegDst=10, ALUOp=000, PCWre=1; PCWre=0 in all earlier states.
- lw (110001) then sw (110000): lw follows 000,001,010,011,100 with mRD=1 in MEM and WB_LD and RegWre=1 only in WB_LD. sw follows 000,001,010,011 with mWR=1 only in MEM.
- beq (110100): zero=1 gives PCSrc=01 in EXE_BR; zero=0 gives PCSrc=00. bne (110101) gives the inverse. Both take 3 cycles with ALUOp=001.
- jal (111010): in ID, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1; next state 000. halt (111111): state stays 001 for 20 cycles with all enables 0.
- Reset in MEM of sw: RST=0 at that edge gives mWR=0 and PCWre=0, then state=000.
